// File: rtl/mc_ctrl_pkg.sv
// Types, opcode constants and datapath select encodings for the multi-cycle RV32I control FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {CL_LW, CL_SW, CL_R, CL_I, CL_BEQ, CL_JAL, CL_BAD} iclass_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;
    localparam logic [1:0] IMM_J      = 2'b11;

    typedef struct packed {
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       ir_fetch;   // ir_write/pc_write gated by mem_ready
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctl_t;

    function automatic ctl_t ctl_for(state_t s);
        ctl_t c;
        c            = '0;
        c.result_src = RES_ALUOUT;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALU_ADD;
        case (s)
            FETCH: begin
                c.mem_read   = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
                c.ir_fetch   = 1'b1;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                c.adr_src  = 1'b1;
                c.mem_read = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_op    = ALU_FUNCT;
            end
            EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_FUNCT;
            end
            ALUWB: c.reg_write = 1'b1;
            BEQ: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_op    = ALU_SUB;
                c.branch    = 1'b1;
            end
            JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            TRAP: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath (slave).
// MCCTRL_PERF_EN adds the cycle_cnt/instret performance counters.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state;
`ifdef MCCTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, mem_read, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal, state,
               cycle_cnt, instret
    );
    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, mem_read, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal, state,
               cycle_cnt, instret
    );
`else
    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, mem_read, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal, state
    );
    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, mem_read, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal, state
    );
`endif
endinterface

// File: rtl/mc_op_decode.sv
// Opcode classifier: instruction class, immediate format and legality from instr[6:0].
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output iclass_t    iclass_o,
    output logic [1:0] imm_src_o,
    output logic       legal_o
);

    always_comb begin
        iclass_o  = CL_BAD;
        imm_src_o = IMM_I;
        case (op_i)
            OP_LW:  iclass_o = CL_LW;
            OP_SW: begin
                iclass_o  = CL_SW;
                imm_src_o = IMM_S;
            end
            OP_R:   iclass_o = CL_R;
            OP_I:   iclass_o = CL_I;
            OP_BEQ: begin
                iclass_o  = CL_BEQ;
                imm_src_o = IMM_B;
            end
            OP_JAL: begin
                iclass_o  = CL_JAL;
                imm_src_o = IMM_J;
            end
            default: ;
        endcase
    end

    assign legal_o = (iclass_o != CL_BAD);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core; Moore enables registered alongside the state.
// MCCTRL_PERF_EN adds free-running cycle and retired-instruction counters.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);

    state_t     state_q, state_d;
    ctl_t       ctl_q;
    iclass_t    iclass;
    logic [1:0] imm_src;
    logic       legal;
    logic       fetch_done;

    mc_op_decode u_dec (
        .op_i      (bus.op),
        .iclass_o  (iclass),
        .imm_src_o (imm_src),
        .legal_o   (legal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                if (!legal) begin
                    state_d = TRAP;
                end else begin
                    case (iclass)
                        CL_LW, CL_SW: state_d = MEMADR;
                        CL_R:         state_d = EXECR;
                        CL_I:         state_d = EXECI;
                        CL_BEQ:       state_d = BEQ;
                        CL_JAL:       state_d = JAL;
                        default:      state_d = TRAP;
                    endcase
                end
            end
            MEMADR:              state_d = (iclass == CL_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
            MEMWRITE: if (bus.mem_ready) state_d = FETCH;
            MEMWB, ALUWB, BEQ:   state_d = FETCH;
            EXECR, EXECI, JAL:   state_d = ALUWB;
            TRAP:                state_d = TRAP;
            default:             state_d = FETCH;
        endcase
    end

    // Enables are decoded from the next state so they change together with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ctl_q   <= ctl_for(FETCH);
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_for(state_d);
        end
    end

    // Reset forces FETCH, so the fetch strobe must be masked while rst_n is low.
    assign fetch_done     = rst_n & ctl_q.ir_fetch & bus.mem_ready;
    assign bus.ir_write   = fetch_done;
    assign bus.pc_write   = fetch_done | ctl_q.pc_update | (ctl_q.branch & bus.zero);
    assign bus.adr_src    = ctl_q.adr_src;
    assign bus.mem_read   = ctl_q.mem_read;
    assign bus.mem_write  = ctl_q.mem_write;
    assign bus.result_src = ctl_q.result_src;
    assign bus.alu_src_a  = ctl_q.alu_src_a;
    assign bus.alu_src_b  = ctl_q.alu_src_b;
    assign bus.alu_op     = ctl_q.alu_op;
    assign bus.reg_write  = ctl_q.reg_write;
    assign bus.illegal    = ctl_q.illegal;
    assign bus.imm_src    = imm_src;
    assign bus.state      = state_q;

`ifdef MCCTRL_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instret_q;
    logic        retire;

    assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                    ((state_q == MEMWRITE) && bus.mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instret_q   <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instret   = instret_q;
`else
    // Counters compiled out; sequencing is identical.
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an instruction-level reference model.
module tb_multicycle_ctrl;
    import mc_ctrl_pkg::*;

    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
    multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an instruction is a fixed list of phases; memory phases repeat while not ready.
    function automatic state_t plan_at(input logic [6:0] o, input int i);
        state_t p [5];
        case (o)
            OPC_LW:  p = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
            OPC_SW:  p = '{FETCH, DECODE, MEMADR, MEMWRITE, FETCH};
            OPC_R:   p = '{FETCH, DECODE, EXECR, ALUWB, FETCH};
            OPC_I:   p = '{FETCH, DECODE, EXECI, ALUWB, FETCH};
            OPC_BEQ: p = '{FETCH, DECODE, BEQ, FETCH, FETCH};
            OPC_JAL: p = '{FETCH, DECODE, JAL, ALUWB, FETCH};
            default: p = '{FETCH, DECODE, TRAP, TRAP, TRAP};
        endcase
        if (i < 0 || i > 4) return FETCH;
        return p[i];
    endfunction

    // Zero-wait CPI of each instruction; illegal ops never complete.
    function automatic int plan_len(input logic [6:0] o);
        case (o)
            OPC_LW:                  return 5;
            OPC_SW, OPC_R, OPC_I,
            OPC_JAL:                 return 4;
            OPC_BEQ:                 return 3;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit advances(input logic [6:0] o, input int pos, input logic mr);
        state_t ph;
        ph = plan_at(o, pos);
        if (ph == TRAP) return 1'b0;
        if (ph == FETCH || ph == MEMREAD || ph == MEMWRITE) return mr;
        return 1'b1;
    endfunction

    typedef struct packed {
        logic       adr, mrd, mwr, rw, ill;
        logic [1:0] res, sa, sb, aop;
    } exp_t;

    function automatic exp_t exp_for(input state_t ph);
        exp_t e;
        e = '0;
        case (ph)
            FETCH:    begin e.mrd = 1; e.sb = 2'b10; e.res = 2'b10; end
            DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
            MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
            MEMREAD:  begin e.adr = 1; e.mrd = 1; end
            MEMWRITE: begin e.adr = 1; e.mwr = 1; end
            MEMWB:    begin e.res = 2'b01; e.rw = 1; end
            EXECR:    begin e.sa = 2'b10; e.aop = 2'b10; end
            EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
            ALUWB:    e.rw = 1;
            BEQ:      begin e.sa = 2'b10; e.aop = 2'b01; end
            JAL:      begin e.sa = 2'b01; e.sb = 2'b10; end
            TRAP:     e.ill = 1;
            default:  ;
        endcase
        return e;
    endfunction

    function automatic logic [1:0] imm_exp(input logic [6:0] o);
        case (o)
            OPC_SW:  return 2'b01;
            OPC_BEQ: return 2'b10;
            OPC_JAL: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    int          m_pos     = 0;
    logic [31:0] m_cycles  = '0;
    logic [31:0] m_instret = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos     <= 0;
            m_cycles  <= '0;
            m_instret <= '0;
        end else begin
            m_cycles <= m_cycles + 32'd1;
            if (advances(bus.op, m_pos, bus.mem_ready)) begin
                if (m_pos + 1 == plan_len(bus.op)) begin
                    m_pos     <= 0;
                    m_instret <= m_instret + 32'd1;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        state_t ph;
        exp_t   e;
        if (cmp_en) begin
            ph = plan_at(bus.op, m_pos);
            e  = exp_for(ph);
            check("state", 32'(bus.state), 32'(ph));
            check("ctl", 32'({bus.adr_src, bus.mem_read, bus.mem_write, bus.reg_write, bus.illegal,
                              bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op}), 32'(e));
            check("ir_write", 32'(bus.ir_write), 32'(rst_n && ph == FETCH && bus.mem_ready));
            check("pc_write", 32'(bus.pc_write),
                  32'((rst_n && ph == FETCH && bus.mem_ready) || ph == JAL || (ph == BEQ && bus.zero)));
            check("imm_src", 32'(bus.imm_src), 32'(imm_exp(bus.op)));
`ifdef MCCTRL_PERF_EN
            check("cycle_cnt", bus.cycle_cnt, m_cycles);
            check("instret", bus.instret, m_instret);
`endif
        end
    end

    int r_cycles, r_irw, r_pcw, r_rw, r_mrd, r_aluf;

    // Runs one instruction from FETCH; call at #1 after the edge that entered FETCH.
    task automatic run_instr(input logic [6:0] o, input int fw_in, input int mw_in, input logic z,
                             input int max_cyc);
        int     fw, mw;
        bit     started;
        state_t ph;
        fw = fw_in; mw = mw_in; started = 1'b0;
        r_cycles = 0; r_irw = 0; r_pcw = 0; r_rw = 0; r_mrd = 0; r_aluf = 0;
        bus.op = o;
        bus.zero = z;
        while (!(started && m_pos == 0) && r_cycles < max_cyc) begin
            ph = plan_at(o, m_pos);
            if (ph != FETCH) started = 1'b1;
            case (ph)
                FETCH: begin
                    bus.mem_ready = (fw == 0);
                    if (fw > 0) fw--;
                end
                MEMREAD, MEMWRITE: begin
                    bus.mem_ready = (mw == 0);
                    if (mw > 0) mw--;
                end
                default: bus.mem_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            r_irw  += int'(bus.ir_write);
            r_pcw  += int'(bus.pc_write);
            r_rw   += int'(bus.reg_write);
            r_mrd  += int'(bus.mem_read);
            r_aluf += int'(bus.alu_op == 2'b10);
            @(posedge clk); #1;
            r_cycles++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [6:0] pick_op();
        int r;
        r = $urandom_range(0, 19);
        case (r % 6)
            0: pick_op = OPC_LW;
            1: pick_op = OPC_SW;
            2: pick_op = OPC_R;
            3: pick_op = OPC_I;
            4: pick_op = OPC_BEQ;
            default: pick_op = OPC_JAL;
        endcase
        if (r >= 18) pick_op = 7'($urandom_range(0, 127));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int trap_cnt;
        bus.op = OPC_R;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        cmp_en = 1'b1;

        @(negedge clk);
        check("rst_state", 32'(bus.state), 32'(FETCH));
        check("rst_mem_read", 32'(bus.mem_read), 32'd1);
        check("rst_alu_src_b", 32'(bus.alu_src_b), 32'd2);
        check("rst_pc_write", 32'(bus.pc_write), 32'd0);
        check("rst_ir_write", 32'(bus.ir_write), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr(OPC_R, 0, 0, 1'b0, 20);
        check("r_cycles", 32'(r_cycles), 32'd4);
        check("r_ir_pulses", 32'(r_irw), 32'd1);
        check("r_reg_write", 32'(r_rw), 32'd1);
        check("r_aluop_funct", 32'(r_aluf), 32'd1);

        run_instr(OPC_LW, 2, 1, 1'b0, 20);
        check("lw_cycles", 32'(r_cycles), 32'd8);
        check("lw_ir_pulses", 32'(r_irw), 32'd1);
        check("lw_mem_read_cycles", 32'(r_mrd), 32'd5);
        check("lw_reg_write", 32'(r_rw), 32'd1);

        run_instr(OPC_BEQ, 0, 0, 1'b1, 20);
        check("beq_taken_cycles", 32'(r_cycles), 32'd3);
        check("beq_taken_pc_write", 32'(r_pcw), 32'd2);
        run_instr(OPC_BEQ, 0, 0, 1'b0, 20);
        check("beq_nt_pc_write", 32'(r_pcw), 32'd1);
        check("beq_imm_src", 32'(bus.imm_src), 32'd2);

        run_instr(OPC_JAL, 0, 0, 1'b0, 20);
        check("jal_cycles", 32'(r_cycles), 32'd4);
        check("jal_pc_write", 32'(r_pcw), 32'd2);
        run_instr(OPC_SW, 1, 1, 1'b0, 20);
        check("sw_cycles", 32'(r_cycles), 32'd6);
        check("sw_reg_write", 32'(r_rw), 32'd0);
        run_instr(OPC_I, 0, 0, 1'b0, 20);
        check("i_cycles", 32'(r_cycles), 32'd4);

        run_instr(OPC_BAD, 0, 0, 1'b0, 5);
        check("trap_illegal", 32'(bus.illegal), 32'd1);
        check("trap_state", 32'(bus.state), 32'(TRAP));
        repeat (3) @(posedge clk);
        #1;
        check("trap_sticky", 32'(bus.illegal), 32'd1);
        rst_n = 1'b0;
        #1;
        check("trap_rst_state", 32'(bus.state), 32'(FETCH));
        check("trap_rst_illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        bus.op = OPC_SW;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        check("memwrite_active", 32'(bus.mem_write), 32'd1);
        #2;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check("async_mem_write", 32'(bus.mem_write), 32'd0);
        check("async_state", 32'(bus.state), 32'(FETCH));
        check("async_pc_write", 32'(bus.pc_write), 32'd0);
        check("async_ir_write", 32'(bus.ir_write), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef MCCTRL_PERF_EN
        do_reset();
        run_instr(OPC_SW, 0, 0, 1'b0, 20);
        run_instr(OPC_BEQ, 0, 0, 1'b1, 20);
        run_instr(OPC_JAL, 0, 0, 1'b0, 20);
        check("perf_instret", bus.instret, 32'd3);
        check("perf_cycle_cnt", bus.cycle_cnt, 32'd11);
`endif

        trap_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (trap_cnt > 3 || $urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                trap_cnt = 0;
                bus.mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            if (m_pos == 0) bus.op = pick_op();
            bus.mem_ready = ($urandom_range(0, 2) != 0);
            bus.zero = 1'($urandom_range(0, 1));
            if (plan_at(bus.op, m_pos) == TRAP) trap_cnt++;
            @(posedge clk); #1;
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I core. It sequences the shared datapath through fetch, decode, execute, memory and writeback over several cycles, and stalls on a memory ready handshake. It drives the ALU controller's 2-bit ALUOp, the datapath multiplexer selects and the register, IR, PC and memory enables. Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  asynchronous reset, active-low
- op  in  7  instr[6:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  read request, held until mem_ready
- mem_write  out  1  write request, held until mem_ready
- ir_write  out  1  IR and OldPC load enable
- result_src  out  2  00=ALUOut, 01=Data, 10=ALU result
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- reg_write  out  1  register file write enable
- illegal  out  1  sticky unsupported-opcode flag
- state  out  4  current state, debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- Transitions:
  - FETCH→DECODE when mem_ready=1; otherwise hold.
  - DECODE→ lw/sw:MEMADR, R:EXECR, I:EXECI, beq:BEQ, jal:JAL, any other op:TRAP.
  - MEMADR→MEMREAD for lw (op=0000011), MEMWRITE for sw.
  - MEMREAD→MEMWB when mem_ready; MEMWRITE→FETCH when mem_ready.
  - MEMWB, ALUWB, BEQ→FETCH. EXECR, EXECI, JAL→ALUWB.
  - TRAP holds until reset.
- Outputs not listed for a state are 0.
  - FETCH: mem_read=1, alu_src_b=10, result_src=10, ir_write=mem_ready, pc update=mem_ready.
  - DECODE: alu_src_a=01, alu_src_b=01 (branch target).
  - MEMADR: alu_src_a=10, alu_src_b=01.
  - MEMREAD: adr_src=1, mem_read=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - MEMWB: result_src=01, reg_write=1.
  - EXECR: alu_src_a=10, alu_op=10.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: reg_write=1.
  - BEQ: alu_src_a=10, alu_op=01, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, pc update=1.
- pc_write = pc_update | (branch & zero).
- imm_src is combinational from op: lw/I→00, sw→01, beq→10, jal→11, else 00.
- illegal=1 in TRAP.

## Timing
- rst_n low: state=FETCH immediately (async); pc_write=0 and ir_write=0 while rst_n=0; other outputs take their FETCH values.
- Reset mid-instruction aborts it; the next fetch begins on the first clk after release.
- Enables are Moore from the state register, except ir_write/pc_write, which also depend on mem_ready/zero in the same cycle.
- CPI with zero-wait memory: lw 5, sw 4, R 4, I 4, beq 3, jal 4; each wait cycle adds 1.
- mem_read/mem_write and the address selects stay stable until the mem_ready cycle.
- A mem_ready that arrives outside FETCH/MEMREAD/MEMWRITE is ignored.

## Configuration
- MCCTRL_PERF_EN defined: adds outputs cycle_cnt[31:0] and instret[31:0], both reset to 0.
  - cycle_cnt increments every clk.
  - instret increments on each exit to FETCH from MEMWB, ALUWB, BEQ, or MEMWRITE with mem_ready.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package mc_ctrl_pkg holds:
  - state_t enum (4-bit)
  - opcode constants
  - alu_op, result_src, alu_src_a/b and imm_src encodings
- One combinational sub-module, mc_op_decode: op → instruction class, imm_src and legal flag.
- The FSM register and output logic live in multicycle_ctrl.

## Test plan
- R-type op=0110011, mem_ready=1: states FETCH, DECODE, EXECR, ALUWB, FETCH. alu_op=10 in EXECR; reg_write=1 only in ALUWB.
- lw with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMREAD: 8 cycles total. mem_read held throughout; ir_write pulses once.
- beq with zero=1 → pc_write=1 in BEQ. With zero=0 → pc_write=0; imm_src=10.
- op=1111111 → DECODE→TRAP, illegal=1 sticky. rst_n pulse low → state=FETCH, illegal=0.
- rst_n asserted during MEMWRITE → mem_write drops without waiting for clk; state=FETCH; pc_write=0 during reset.
- With MCCTRL_PERF_EN: 3 instructions (sw, beq, jal) with zero-wait → instret=3, cycle_cnt=11 at the return to FETCH.
